rgb_led_arbiter: RTL and testbench
==================================

# rgb_led_arbiter

Shares the board's single active-low RGB LED between several on-chip status sources. Each requester presents a 3-bit colour and a request. The arbiter grants the LED round-robin for a fixed dwell time and drives the latched colour onto RGB_R/RGB_G/RGB_B. It sits between the status-producing blocks and the top-level LED pins, replacing direct LED drive.

## Interface

- NUM_REQ, default 4: number of requesters, ≥2.
- DWELL_CYCLES, default 2000000: clock cycles per grant (1/6 s at 12 MHz), ≥2.
- clk  input  1: system clock, 12 MHz.
- rst_n  input  1: reset, asynchronous, active-low.
- req  input  NUM_REQ: level request per requester.
- color  input  3*NUM_REQ: requester i colour at bits [3i+2:3i], ordered {R,G,B}, 1 = lit.
- gnt  output  NUM_REQ: one-hot grant, all zero when idle.
- done  output  NUM_REQ: one-cycle pulse when requester i's dwell completes.
- busy  output  1: high while any grant is active.
- RGB_R, RGB_G, RGB_B  output  1 each: LED drive, active-low (0 = on).

## Operation

- FSM with two states: IDLE and SHOW.
- IDLE:
  - LED off (all RGB = 1), gnt = 0, busy = 0.
  - If any req is high, grant the first high req searching from ptr+1 (mod NUM_REQ), latch that requester's colour, clear the dwell counter and go to SHOW.
- SHOW:
  - Drive the inverted latched colour onto the LED. gnt is one-hot on the owner and busy = 1.
  - The dwell counter increments each cycle.
  - **Normal end:** the counter reaches DWELL_CYCLES-1 and the owner's req is still high.
    - Pulse done[owner], set ptr = owner.
    - If another grant is possible, re-arbitrate on the same edge, with no idle cycle. Otherwise go to IDLE.
  - **Release:** the owner's req is low in any SHOW cycle.
    - End the slot on that edge, with no done pulse.
    - Set ptr = owner and re-arbitrate exactly as for a normal end.
- Re-arbitration includes the previous owner, at lowest priority. A sole requester holding req is re-granted immediately, and done still pulses for each completed slot.
- Colour is latched only at the grant edge. Changes on color during SHOW are ignored.
- Owner req low on the final count cycle is a release: no done pulse.
- The dwell counter is $clog2(DWELL_CYCLES) bits and is cleared on every grant.
- ptr resets to NUM_REQ-1, so requester 0 has first priority after reset.

## Timing

- Reset values, applied asynchronously on rst_n low at any time including mid-SHOW:
  - state = IDLE, gnt = 0, done = 0, busy = 0.
  - RGB_R = RGB_G = RGB_B = 1.
  - counter = 0, ptr = NUM_REQ-1.
- Grant latency: req sampled high at edge k gives gnt, busy and LED valid after edge k. This is one registered cycle from req assertion, and all outputs are registered.
- Slot length: gnt is high for exactly DWELL_CYCLES cycles on a normal end.
- done is high for the single cycle after the ending edge. The next requester's gnt becomes valid in that same cycle.
- Release: owner req seen low at edge k means gnt drops after edge k.

## Structure

- Package rgb_pkg:
  - LED_ON = 1'b0 and LED_OFF = 1'b1.
  - typedef rgb_color_t (logic [2:0]).
  - Colour constants RED, YELLOW, GREEN, CYAN, BLUE, MAGENTA, OFF.
  - Enum arb_state_t {IDLE, SHOW}.
- Sub-module rr_priority_pick: combinational round-robin select. Inputs are req, the req-valid mask and ptr. Outputs are a one-hot winner and a valid flag. The FSM, counter and registers stay in rgb_led_arbiter.

## Test plan

Bench parameters: NUM_REQ = 4, DWELL_CYCLES = 4.

1. **Single request.** req = 0001 with color0 = 100 asserted before edge 1.
   - Required: after edge 1, gnt = 0001 and RGB = {0,1,1}.
   - After edge 5, done = 0001 and gnt is re-granted to 0001.
2. **Post-reset order.** All four req high from reset release.
   - Required: grants 0001, 0010, 0100, 1000, 0001, each 4 cycles long, back-to-back with no idle cycle.
   - done pulses for 0, 1, 2, 3 in that order.
3. **Early release.** req0 drops 2 cycles into its slot while req2 is high.
   - Required: gnt0 falls on the next edge, no done pulse, and gnt = 0100 in that same cycle.
4. **Colour change ignored.** color1 changes 011 → 101 mid-slot.
   - Required: LED holds {1,0,0} until the slot ends.
5. **Reset mid-slot.** rst_n pulsed low mid-SHOW.
   - Required: gnt = 0, busy = 0 and RGB = 111 immediately, without waiting for a clock.
   - After release, requester 0 wins first.
6. **Release on final count.** Owner req low on the final count cycle.
   - Required: no done pulse, and the slot ends normally.

Source files
------------

// File: rtl/rgb_pkg.sv
// rgb_pkg: shared LED polarity, colour and arbiter state definitions
package rgb_pkg;
    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;
    typedef logic [2:0] rgb_color_t;
    localparam rgb_color_t RED     = 3'b100;
    localparam rgb_color_t YELLOW  = 3'b110;
    localparam rgb_color_t GREEN   = 3'b010;
    localparam rgb_color_t CYAN    = 3'b011;
    localparam rgb_color_t BLUE    = 3'b001;
    localparam rgb_color_t MAGENTA = 3'b101;
    localparam rgb_color_t OFF     = 3'b000;
    typedef enum logic {IDLE, SHOW} arb_state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin select, searching from ptr+1 so ptr itself is lowest priority
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);
    logic [PW-1:0] idx;
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (win == '0 && req[idx] && mask[idx]) win[idx] = 1'b1;
        end
        valid = |win;
    end
endmodule

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: round-robin time-sharing of one active-low RGB LED between status sources
module rgb_led_arbiter
    import rgb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 2000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   color,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic                   RGB_R,
    output logic                   RGB_G,
    output logic                   RGB_B
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DWELL_CYCLES);

    arb_state_t         state_q;
    logic [NUM_REQ-1:0] gnt_q, done_q, win;
    rgb_color_t         led_q;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      ptr_q, owner_q, win_idx;
    logic               win_valid, slot_end;

    // A slot ends on the final count or as soon as the owner lets go of req
    assign slot_end = (state_q == SHOW) && (!req[owner_q] || cnt_q == CW'(DWELL_CYCLES - 1));

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .mask  ({NUM_REQ{1'b1}}),
        .ptr   (state_q == SHOW ? owner_q : ptr_q),
        .win   (win),
        .valid (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) if (win[i]) win_idx = PW'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            led_q   <= {3{LED_OFF}};
            cnt_q   <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
            owner_q <= '0;
        end else begin
            done_q <= '0;
            if (state_q == IDLE || slot_end) begin
                if (slot_end) begin
                    done_q[owner_q] <= req[owner_q];
                    ptr_q           <= owner_q;
                end
                state_q <= win_valid ? SHOW : IDLE;
                gnt_q   <= win;
                owner_q <= win_idx;
                cnt_q   <= '0;
                led_q   <= win_valid ? ~color[3*int'(win_idx) +: 3] : {3{LED_OFF}};
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = (state_q == SHOW);
    assign RGB_R = led_q[2];
    assign RGB_G = led_q[1];
    assign RGB_B = led_q[0];
endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: directed plan scenarios plus random traffic against a slot-level reference model
module tb_rgb_led_arbiter;
    localparam int N  = 4;
    localparam int DW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req = '0;
    logic [3*N-1:0] color = '0;
    logic [N-1:0]   gnt, done;
    logic           busy, RGB_R, RGB_G, RGB_B;

    int n_checks = 0;
    int n_errors = 0;

    int           owner, age, ptr;
    logic [2:0]   col;
    logic [N-1:0] exp_done;

    rgb_led_arbiter #(.NUM_REQ(N), .DWELL_CYCLES(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .color(color),
        .gnt(gnt), .done(done), .busy(busy),
        .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner    = -1;
        age      = 0;
        ptr      = N - 1;
        exp_done = '0;
    endtask

    // One clock edge of the slot-level model: age the current slot, then fill an empty LED
    task automatic model_step();
        exp_done = '0;
        if (owner >= 0) begin
            age++;
            if (!req[owner] || age == DW) begin
                if (req[owner]) exp_done[owner] = 1'b1;
                ptr   = owner;
                owner = -1;
            end
        end
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (owner < 0 && req[i]) begin
                owner = i;
                age   = 0;
                col   = color[3*i +: 3];
            end
        end
    endtask

    task automatic compare_all();
        logic [2:0] exp_rgb;
        exp_rgb = (owner < 0) ? 3'b111 : ~col;
        check("gnt", 32'(gnt), (owner < 0) ? 32'd0 : (32'd1 << owner));
        check("done", 32'(done), 32'(exp_done));
        check("busy", 32'(busy), 32'(owner >= 0));
        check("rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'(exp_rgb));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'h7);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // single requester, red
        req   = 4'b0001;
        color = 12'h004;
        tick();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'h3);
        repeat (4) tick();
        check("t1_done", 32'(done), 32'h1);
        check("t1_regrant", 32'(gnt), 32'h1);
        req = '0;
        repeat (3) tick();

        // all four from reset: strict order, back-to-back slots
        do_reset();
        req   = 4'b1111;
        color = 12'($urandom);
        for (int s = 0; s < 5; s++) begin
            tick();
            check("t2_gnt", 32'(gnt), 32'd1 << (s % 4));
            check("t2_done", 32'(done), (s == 0) ? 32'd0 : (32'd1 << (s - 1)));
            repeat (3) tick();
        end

        // early release hands over on the same edge
        do_reset();
        req = 4'b0101;
        repeat (2) tick();
        req = 4'b0100;
        tick();
        check("t3_gnt", 32'(gnt), 32'h4);
        check("t3_done", 32'(done), 32'h0);
        repeat (4) tick();

        // colour changes mid-slot are ignored
        do_reset();
        req   = 4'b0010;
        color = 12'b000_000_011_000;
        tick();
        check("t4_rgb0", 32'({RGB_R, RGB_G, RGB_B}), 32'h4);
        tick();
        color = 12'b000_000_101_000;
        repeat (2) begin
            tick();
            check("t4_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'h4);
        end
        tick();
        check("t4_newcol", 32'({RGB_R, RGB_G, RGB_B}), 32'h2);

        // reset mid-slot, requester 0 wins afterwards
        req = 4'b1111;
        repeat (6) tick();
        do_reset();
        tick();
        check("t5_gnt", 32'(gnt), 32'h1);

        // release on the final count cycle
        do_reset();
        req = 4'b0001;
        repeat (4) tick();
        req = '0;
        tick();
        check("t6_done", 32'(done), 32'h0);
        check("t6_gnt", 32'(gnt), 32'h0);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(7) == 0) req[$urandom_range(N - 1)] ^= 1'b1;
            if ($urandom_range(3) == 0) color = 12'($urandom);
            if ($urandom_range(149) == 0) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
